// File: rtl/thermo_pkg.sv
// Shared definitions for thermometer-code consumers: peak FSM states,
// the bubble counter width and the legal-code mask helper.
package thermo_pkg;

    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        HOLD   = 2'd1,
        DECAY  = 2'd2
    } peak_state_e;

    localparam int ERRCNT_W = 8;

    // Thermometer pattern with the low n bits set; callers truncate to their width.
    function automatic logic [63:0] therm_mask(input int unsigned n);
        if (n >= 64) begin
            return '1;
        end
        return (64'd1 << n) - 64'd1;
    endfunction

endpackage

// File: rtl/thermo_popcount.sv
// Ones-count decode of a W-bit thermometer code with a legality flag that
// is set only when the input is exactly the contiguous-from-bit-0 pattern.
module thermo_popcount
    import thermo_pkg::*;
#(
    parameter int K = 3,
    parameter int W = 7
) (
    input  logic [W-1:0] therm_in,
    output logic [K-1:0] count,
    output logic         legal
);

    // Per-bit zero extension keeps the adder chain free of width mismatches.
    logic [K-1:0] bit_ext [W];

    for (genvar gi = 0; gi < W; gi++) begin : g_ext
        assign bit_ext[gi] = K'(therm_in[gi]);
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + bit_ext[i];
        end
    end

    assign legal = (therm_in == W'(therm_mask(int'(count))));

endmodule

// File: rtl/thermo_peak_meter.sv
// Thermometer-code level meter with bubble detection and peak-hold/decay.
// Optional saturating bubble counter enabled by THERMO_PEAK_ERRCNT_EN.
module thermo_peak_meter
    import thermo_pkg::*;
#(
    parameter int K            = 3,
    parameter int W            = 7,
    parameter int HOLD_CYCLES  = 16,
    parameter int DECAY_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [W-1:0]        therm_in,
    output logic [K-1:0]        level,
    output logic                level_valid,
    output logic [K-1:0]        peak,
    output logic                bubble_err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DCW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LOAD  = HCW'(HOLD_CYCLES - 1);
    localparam logic [DCW-1:0] DECAY_LOAD = DCW'(DECAY_CYCLES - 1);
    localparam logic [K:0]     ONE_EXT    = (K+1)'(1);

    if (W != (2**K) - 1) begin : g_bad_width
        $error("thermo_peak_meter: W must equal 2**K-1");
    end
    if (HOLD_CYCLES < 1 || DECAY_CYCLES < 1) begin : g_bad_timing
        $error("thermo_peak_meter: HOLD_CYCLES and DECAY_CYCLES must be >= 1");
    end

    logic [K-1:0] n;
    logic         legal;

    thermo_popcount #(.K(K), .W(W)) u_popcount (
        .therm_in (therm_in),
        .count    (n),
        .legal    (legal)
    );

    logic [K-1:0]   level_reg, peak_reg, peak_next, level_ref;
    logic           level_valid_reg, bubble_err_reg;
    logic [HCW-1:0] hcnt_reg, hcnt_next;
    logic [DCW-1:0] dcnt_reg, dcnt_next;
    peak_state_e    state_reg, state_next;
    logic           rise, settle;

    assign level_ref = in_valid ? n : level_reg;
    assign rise      = in_valid && (n >= peak_reg);
    // Widened compare stands in for peak-1 <= level_ref without wrapping at 0.
    assign settle    = ({1'b0, peak_reg} <= ({1'b0, level_ref} + ONE_EXT));

    always_comb begin
        state_next = state_reg;
        peak_next  = peak_reg;
        hcnt_next  = hcnt_reg;
        dcnt_next  = dcnt_reg;
        case (state_reg)
            FOLLOW: begin
                if (rise) begin
                    peak_next = n;
                end else if (in_valid) begin
                    hcnt_next  = HOLD_LOAD;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (rise) begin
                    peak_next  = n;
                    state_next = FOLLOW;
                end else if (hcnt_reg == '0) begin
                    dcnt_next  = DECAY_LOAD;
                    state_next = DECAY;
                end else begin
                    hcnt_next = hcnt_reg - HCW'(1);
                end
            end
            DECAY: begin
                if (rise) begin
                    peak_next  = n;
                    state_next = FOLLOW;
                end else if (dcnt_reg == '0) begin
                    if (settle) begin
                        peak_next  = level_ref;
                        state_next = FOLLOW;
                    end else begin
                        peak_next = peak_reg - K'(1);
                        dcnt_next = DECAY_LOAD;
                    end
                end else begin
                    dcnt_next = dcnt_reg - DCW'(1);
                end
            end
            default: begin
                state_next = FOLLOW;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg       <= '0;
            level_valid_reg <= 1'b0;
            bubble_err_reg  <= 1'b0;
            peak_reg        <= '0;
            hcnt_reg        <= '0;
            dcnt_reg        <= '0;
            state_reg       <= FOLLOW;
        end else begin
            level_valid_reg <= in_valid;
            bubble_err_reg  <= in_valid && !legal;
            if (in_valid) begin
                level_reg <= n;
            end
            peak_reg  <= peak_next;
            hcnt_reg  <= hcnt_next;
            dcnt_reg  <= dcnt_next;
            state_reg <= state_next;
        end
    end

    assign level       = level_reg;
    assign level_valid = level_valid_reg;
    assign peak        = peak_reg;
    assign bubble_err  = bubble_err_reg;

`ifdef THERMO_PEAK_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (in_valid && !legal && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + ERRCNT_W'(1);
        end
    end

    assign err_count = err_cnt_reg;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_thermo_peak_meter.sv
// Directed plus randomized bench for thermo_peak_meter against a behavioural
// model that tracks elapsed clocks since a peak drop.
module tb_thermo_peak_meter;

    localparam int K = 3;
    localparam int W = 7;
    localparam int H = 16;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] therm_in = '0;
    logic [K-1:0] level, peak;
    logic         level_valid, bubble_err;
    logic [7:0]   err_count;

    int checks = 0;
    int failures = 0;
    int nstep = 0;

    // Reference model state
    int mlevel, mpeak, mlv, mbub, merr, mt;
    bit mactive;

    thermo_peak_meter #(.K(K), .W(W), .HOLD_CYCLES(H), .DECAY_CYCLES(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .therm_in    (therm_in),
        .level       (level),
        .level_valid (level_valid),
        .peak        (peak),
        .bubble_err  (bubble_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mlevel = 0; mpeak = 0; mlv = 0; mbub = 0; merr = 0; mt = 0; mactive = 0;
    endtask

    task automatic model_update(input bit v, input logic [W-1:0] c);
        int cnt;
        int lref;
        bit ok;
        logic [W-1:0] mask;
        cnt = 0;
        for (int i = 0; i < W; i++) cnt += int'(c[i]);
        mask = W'((1 << cnt) - 1);
        ok = (c == mask);
        lref = v ? cnt : mlevel;
        if (v && cnt >= mpeak) begin
            mpeak = cnt;
            mactive = 0;
        end else if (!mactive) begin
            if (v) begin
                mactive = 1;
                mt = 0;
            end
        end else begin
            mt++;
            if (mt > H && ((mt - H) % D) == 0) begin
                if (mpeak - 1 <= lref) begin
                    mpeak = lref;
                    mactive = 0;
                end else begin
                    mpeak = mpeak - 1;
                end
            end
        end
        mlv = v;
        mbub = v && !ok;
        if (v) mlevel = cnt;
`ifdef THERMO_PEAK_ERRCNT_EN
        if (v && !ok && merr < 255) merr++;
`endif
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(mlevel));
        chk({tag, ".level_valid"}, 32'(level_valid), 32'(mlv));
        chk({tag, ".peak"}, 32'(peak), 32'(mpeak));
        chk({tag, ".bubble_err"}, 32'(bubble_err), 32'(mbub));
        chk({tag, ".err_count"}, 32'(err_count), 32'(merr));
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs sampled likewise.
    task automatic step(input string tag, input bit v, input logic [W-1:0] c);
        in_valid = v;
        therm_in = c;
        @(posedge clk);
        model_update(v, c);
        #1;
        check_all(tag);
        nstep++;
        $display("step %0d %s v=%0b code=%b level=%0d lv=%0b peak=%0d bub=%0b errc=%0d",
                 nstep, tag, v, c, level, level_valid, peak, bubble_err, err_count);
    endtask

    initial begin
        int guard;
        int expect_err;
        logic [W-1:0] rc;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step("first", 1'b1, 7'b0001111);
        chk("first.level_const", 32'(level), 32'd4);
        chk("first.peak_const", 32'(peak), 32'd4);

        step("bubble", 1'b1, 7'b0001011);
        chk("bubble.level_const", 32'(level), 32'd3);
        chk("bubble.flag_const", 32'(bubble_err), 32'd1);
        for (int i = 0; i < 300; i++) step("bubble_run", 1'b1, 7'b0001011);
`ifdef THERMO_PEAK_ERRCNT_EN
        expect_err = 255;
`else
        expect_err = 0;
`endif
        chk("err_sat", 32'(err_count), 32'(expect_err));

        step("decay_top", 1'b1, 7'b1111111);
        for (int i = 0; i < 45; i++) step("decay_seq", 1'b1, 7'b0000011);
        chk("decay_final_peak", 32'(peak), 32'd2);

        step("rise_top", 1'b1, 7'b1111111);
        guard = 0;
        while (mpeak != 5 && guard < 60) begin
            step("rise_wait", 1'b1, 7'b0000011);
            guard++;
        end
        chk("rise_reached_5", 32'(guard < 60), 32'd1);
        step("rise_hit", 1'b1, 7'b0111111);
        chk("rise_peak_const", 32'(peak), 32'd6);
        step("rise_after", 1'b1, 7'b0000011);
        chk("rise_hold_const", 32'(peak), 32'd6);

        step("idle_top", 1'b1, 7'b1111111);
        step("idle_zero", 1'b1, 7'b0000000);
        for (int i = 0; i < 20; i++) step("idle", 1'b0, W'($urandom));
        for (int i = 0; i < 20; i++) step("idle_more", 1'b0, 7'b0);

        step("hold_top", 1'b1, 7'b1111111);
        step("hold_drop", 1'b1, 7'b0000011);
        step("hold_mid", 1'b0, 7'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_reset", 1'b1, 7'b0000001);
        chk("post_reset.level_const", 32'(level), 32'd1);
        chk("post_reset.peak_const", 32'(peak), 32'd1);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) rc = W'($urandom);
            else rc = W'((1 << $urandom_range(0, W)) - 1);
            step("random", ($urandom_range(0, 9) < 4), rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
